// File: rtl/card_pkg.sv
// Shared constants, FSM encoding and rank helpers for the card dealer and hand accumulators.
package card_pkg;

    localparam int unsigned NUM_RANKS = 13;
    localparam int unsigned NUM_SUITS = 4;
    localparam int unsigned DECK_SIZE = 52;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSearch = 2'd1,
        StDone   = 2'd2
    } dealer_state_e;

    // Blackjack value of a rank 1..13; face cards count 10, Ace counts 1.
    function automatic logic [3:0] rank_to_points(input logic [3:0] rank);
        return (rank > 4'd10) ? 4'd10 : rank;
    endfunction

    // Folds a 4-bit seed nibble 0..15 onto rank index 0..12.
    function automatic logic [3:0] seed_to_idx(input logic [3:0] nibble);
        return (nibble <= 4'd12) ? nibble : nibble - 4'd13;
    endfunction

endpackage

// File: rtl/deck_store.sv
// Per-rank card counters plus the running total of cards left in the deck.
module deck_store
    import card_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       refill_i,
    input  logic       dec_i,
    input  logic [3:0] idx_i,
    output logic [2:0] count_o,
    output logic [5:0] remaining_o
);

    localparam logic [2:0] FullCount = 3'(NUM_SUITS);
    localparam logic [5:0] FullDeck  = 6'(DECK_SIZE);

    logic [2:0] cnt_q [NUM_RANKS];
    logic [2:0] cnt_d [NUM_RANKS];
    logic [5:0] rem_q, rem_d;

    logic idx_ok;
    assign idx_ok = (idx_i < 4'(NUM_RANKS));

    always_comb begin
        cnt_d = cnt_q;
        rem_d = rem_q;
        if (refill_i) begin
            for (int r = 0; r < NUM_RANKS; r++) begin
                cnt_d[r] = FullCount;
            end
            rem_d = FullDeck;
        end else if (dec_i && idx_ok) begin
            cnt_d[idx_i] = cnt_q[idx_i] - 3'd1;
            rem_d        = rem_q - 6'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int r = 0; r < NUM_RANKS; r++) begin
                cnt_q[r] <= FullCount;
            end
            rem_q <= FullDeck;
        end else begin
            cnt_q <= cnt_d;
            rem_q <= rem_d;
        end
    end

    assign count_o     = idx_ok ? cnt_q[idx_i] : 3'd0;
    assign remaining_o = rem_q;

endmodule

// File: rtl/card_dealer.sv
// Deals one card per request from a single deck, probing upward from a seeded rank
// until a rank with cards left is found.
module card_dealer
    import card_pkg::*;
#(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk_50M,
    input  logic             i_Reset,
    input  logic [WIDTH-1:0] i_Seed,
    input  logic             i_Req,
    input  logic             i_Shuffle,
    output logic [3:0]       o_Card,
    output logic [3:0]       o_Points,
    output logic             o_Valid,
    output logic             o_Busy,
    output logic             o_Empty,
    output logic [5:0]       o_Remaining
);

    dealer_state_e state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [3:0]    card_q, card_d;
    logic [3:0]    points_q, points_d;
    logic [2:0]    rank_count;
    logic          dec_en;

    // Only the low nibble of the seed is used.
    if (WIDTH > 4) begin : g_seed_unused
        logic unused_seed;
        assign unused_seed = ^i_Seed[WIDTH-1:4];
    end

    deck_store u_deck_store (
        .clk_i       (clk_50M),
        .rst_ni      (i_Reset),
        .refill_i    (i_Shuffle),
        .dec_i       (dec_en),
        .idx_i       (idx_q),
        .count_o     (rank_count),
        .remaining_o (o_Remaining)
    );

    assign o_Empty = (o_Remaining == 6'd0);

    always_ff @(posedge clk_50M) begin
        if (!i_Reset) begin
            state_q  <= StIdle;
            idx_q    <= 4'd0;
            card_q   <= 4'd0;
            points_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            card_q   <= card_d;
            points_q <= points_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        card_d   = card_q;
        points_d = points_q;
        if (i_Shuffle) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_Req && !o_Empty) begin
                        idx_d   = seed_to_idx(i_Seed[3:0]);
                        state_d = StSearch;
                    end
                end
                StSearch: begin
                    if (rank_count != 3'd0) begin
                        card_d   = idx_q + 4'd1;
                        points_d = rank_to_points(idx_q + 4'd1);
                        state_d  = StDone;
                    end else begin
                        idx_d = (idx_q == 4'(NUM_RANKS - 1)) ? 4'd0 : idx_q + 4'd1;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // A shuffle overrides the deal, so it also masks the pulse and the decrement.
    always_comb begin
        dec_en  = (state_q == StSearch) && (rank_count != 3'd0) && !i_Shuffle;
        o_Valid = (state_q == StDone) && !i_Shuffle;
        o_Busy  = (state_q != StIdle);
    end

    assign o_Card   = card_q;
    assign o_Points = points_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer; expected deals are queued and checked by a monitor on o_Valid.
module tb_card_dealer;

    logic        clk_50M = 1'b0;
    logic        i_Reset;
    logic [11:0] i_Seed;
    logic        i_Req;
    logic        i_Shuffle;
    logic [3:0]  o_Card;
    logic [3:0]  o_Points;
    logic        o_Valid;
    logic        o_Busy;
    logic        o_Empty;
    logic [5:0]  o_Remaining;

    typedef struct {
        int card;
        int pts;
        int rem;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   fails   = 0;
    int   cyc     = 0;
    int   rem_model = 52;

    card_dealer #(.WIDTH(12)) dut (
        .clk_50M     (clk_50M),
        .i_Reset     (i_Reset),
        .i_Seed      (i_Seed),
        .i_Req       (i_Req),
        .i_Shuffle   (i_Shuffle),
        .o_Card      (o_Card),
        .o_Points    (o_Points),
        .o_Valid     (o_Valid),
        .o_Busy      (o_Busy),
        .o_Empty     (o_Empty),
        .o_Remaining (o_Remaining)
    );

    always #10 clk_50M = ~clk_50M;

    always @(posedge clk_50M) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every o_Valid pulse must match the oldest queued expectation.
    always @(negedge clk_50M) begin
        if (o_Valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("card", int'(o_Card), e.card);
                check("points", int'(o_Points), e.pts);
                check("remaining", int'(o_Remaining), e.rem);
                check("valid_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_50M);
            #1;
        end
    endtask

    // Called just after a clock edge with the DUT idle.
    task automatic deal(input logic [11:0] seed, input int card, input int pts, input int skips);
        exp_t e;
        rem_model--;
        e.card = card;
        e.pts  = pts;
        e.rem  = rem_model;
        e.cyc  = cyc + 2 + skips;
        exp_q.push_back(e);
        i_Seed = seed;
        i_Req  = 1'b1;
        tick(1);
        i_Req = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk_50M);
        #1;
        if (exp_q.size() != 0) begin
            check("deal_timeout", 0, 1);
            exp_q.delete();
        end
    endtask

    task automatic shuffle();
        i_Shuffle = 1'b1;
        tick(1);
        i_Shuffle = 1'b0;
        rem_model = 52;
    endtask

    initial begin
        i_Reset   = 1'b0;
        i_Seed    = 12'h000;
        i_Req     = 1'b0;
        i_Shuffle = 1'b0;
        tick(2);
        check("rst_card", int'(o_Card), 0);
        check("rst_points", int'(o_Points), 0);
        check("rst_valid", int'(o_Valid), 0);
        check("rst_busy", int'(o_Busy), 0);
        check("rst_empty", int'(o_Empty), 0);
        check("rst_remaining", int'(o_Remaining), 52);
        i_Reset = 1'b1;
        tick(1);

        // Seed fold
        deal(12'h005, 6, 6, 0);
        deal(12'h00E, 2, 2, 0);
        deal(12'h00C, 13, 10, 0);
        deal(12'h00F, 3, 3, 0);
        shuffle();
        check("shuffle_remaining", int'(o_Remaining), 52);

        // Aces run out, then the search steps to rank 2
        for (int i = 0; i < 4; i++) deal(12'h000, 1, 1, 0);
        deal(12'h000, 2, 2, 1);
        // Kings run out, then the search wraps past the empty Aces
        for (int i = 0; i < 4; i++) deal(12'h00C, 13, 10, 0);
        deal(12'h00C, 2, 2, 2);

        // Drain the deck with seed 0: rank k is reached after k-1 skips
        shuffle();
        for (int i = 0; i < 52; i++) begin
            int c;
            c = i / 4 + 1;
            deal(12'h000, c, (c > 10) ? 10 : c, i / 4);
        end
        check("empty_remaining", int'(o_Remaining), 0);
        check("empty_flag", int'(o_Empty), 1);
        i_Req = 1'b1;
        tick(1);
        i_Req = 1'b0;
        check("empty_req_busy", int'(o_Busy), 0);
        tick(3);
        check("empty_req_busy_late", int'(o_Busy), 0);
        shuffle();
        check("refill_remaining", int'(o_Remaining), 52);
        check("refill_empty", int'(o_Empty), 0);

        // Shuffle while searching aborts the deal
        deal(12'h000, 1, 1, 0);
        i_Seed = 12'h004;
        i_Req  = 1'b1;
        tick(1);
        i_Req = 1'b0;
        check("search_busy", int'(o_Busy), 1);
        shuffle();
        tick(3);
        check("abort_card", int'(o_Card), 1);
        check("abort_remaining", int'(o_Remaining), 52);
        check("abort_busy", int'(o_Busy), 0);

        // Shuffle and request together: no deal
        i_Shuffle = 1'b1;
        i_Req     = 1'b1;
        tick(1);
        i_Shuffle = 1'b0;
        i_Req     = 1'b0;
        check("conflict_busy", int'(o_Busy), 0);
        tick(3);
        check("conflict_remaining", int'(o_Remaining), 52);

        // Reset in the middle of a search
        deal(12'h003, 4, 4, 0);
        i_Seed = 12'h007;
        i_Req  = 1'b1;
        tick(1);
        i_Req   = 1'b0;
        i_Reset = 1'b0;
        tick(1);
        check("mrst_remaining", int'(o_Remaining), 52);
        check("mrst_card", int'(o_Card), 0);
        check("mrst_points", int'(o_Points), 0);
        check("mrst_valid", int'(o_Valid), 0);
        check("mrst_busy", int'(o_Busy), 0);
        i_Reset   = 1'b1;
        rem_model = 52;
        tick(4);
        check("pending_expectations", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/card_dealer.md
# card_dealer

Deals single playing cards from one 52-card deck on request from the game FSM. It uses the free-running count from the counter stage as its random seed. It tracks how many cards of each rank remain, so a deal never returns a rank that is exhausted. Its outputs feed the player/dealer hand accumulators and the FSM's deal sequencing.

## Interface
- WIDTH, 12, width of the seed input; must match the counter's count width (≥4).
- clk_50M  in  1  50 MHz system clock.
- i_Reset  in  1  synchronous, active-low reset.
- i_Seed  in  WIDTH  free-running count from the counter stage; only bits [3:0] are used.
- i_Req  in  1  deal request; sampled only in IDLE.
- i_Shuffle  in  1  refills the deck; accepted in any state.
- o_Card  out  4  dealt rank, 1..13 (1 = Ace, 11..13 = J/Q/K); holds until the next deal.
- o_Points  out  4  blackjack value of o_Card: 1..10, Ace = 1, J/Q/K = 10.
- o_Valid  out  1  one-cycle pulse when o_Card/o_Points update.
- o_Busy  out  1  high whenever state ≠ IDLE.
- o_Empty  out  1  high when o_Remaining = 0.
- o_Remaining  out  6  cards left in the deck, 0..52.

## Operation
- Storage: 13 per-rank counters, 3 bits each, range 0..4; one 6-bit total counter.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - i_Req=1 and o_Empty=0: load idx = s (s = i_Seed[3:0]) if s ≤ 12, else s − 13. Go to SEARCH.
  - i_Req=1 and o_Empty=1: request ignored. No o_Valid, o_Busy stays 0.
- SEARCH, each cycle:
  - count[idx] ≠ 0: decrement count[idx] and o_Remaining. Register o_Card = idx+1 and o_Points = min(idx+1, 10). Go to DONE.
  - count[idx] = 0: idx = (idx == 12) ? 0 : idx+1, with wrap-around. Stay in SEARCH.
  - The deck is non-empty on entry, so a hit is guaranteed within 13 probes.
- DONE: assert o_Valid for this one cycle, then go to IDLE.
- Shuffle:
  - On i_Shuffle=1, all rank counters go to 4, o_Remaining to 52, state to IDLE.
  - In SEARCH or DONE, the pending deal is aborted and o_Valid is suppressed; o_Card/o_Points keep their previous values.
- Priority: reset > shuffle > request. i_Shuffle and i_Req in the same IDLE cycle: shuffle only, no deal started.
- i_Req while busy: ignored, not queued.
- o_Empty is combinational from o_Remaining.

## Timing
- Reset values (applied on the clock edge with i_Reset=0):
  - state IDLE, rank counters 4, o_Remaining 52;
  - o_Card 0, o_Points 0, o_Valid 0, o_Busy 0, o_Empty 0.
- Reset asserted mid-SEARCH or mid-DONE: all reset values apply on that edge, with no o_Valid.
- Latency, with i_Req sampled at edge N:
  - SEARCH is entered at N+1.
  - A first-probe hit gives o_Valid high during cycle N+2.
  - Each skipped rank adds 1 cycle. Maximum latency is 14 cycles (12 skips).
- o_Remaining and the rank counter update on the edge that leaves SEARCH. They are visible in the same cycle o_Valid is high.
- Back-to-back deals: i_Req held high gives one deal every 3+k cycles, one cycle in IDLE between deals.

## Structure
- Shared package card_pkg holds:
  - NUM_RANKS = 13, NUM_SUITS = 4, DECK_SIZE = 52;
  - the state encoding (IDLE/SEARCH/DONE);
  - function rank_to_points(rank);
  - function seed_to_idx(nibble), the fold of 0..15 onto 0..12.
  - The hand accumulators reuse rank_to_points.
- One sub-module, deck_store, holds the 13 rank counters plus the total counter. Its ports are:
  - refill;
  - decrement enable with index;
  - count-at-index read;
  - remaining.
- card_dealer keeps the FSM, the idx register and the output registers.

## Test plan
- Reset release, i_Seed=0x005, 1-cycle i_Req → o_Valid in the 2nd cycle after the request edge; o_Card=6, o_Points=6, o_Remaining=51.
- Seed fold: i_Seed=0x00E → o_Card=2. i_Seed=0x00C → o_Card=13, o_Points=10. i_Seed=0x00F → o_Card=3.
- Exhaustion and wrap:
  - Four deals with seed 0x000 → four Aces, points 1.
  - Fifth deal with seed 0x000 → o_Card=2, latency 3.
  - Exhaust rank 13 and deal with seed 0x00C → wraps to Ace/next available rank.
- Deck empty: 52 consecutive deals → each rank dealt exactly 4 times, then o_Remaining=0 and o_Empty=1.
  - A further i_Req gives no o_Valid and o_Busy=0.
  - i_Shuffle then gives o_Remaining=52 and o_Empty=0.
- Shuffle conflicts:
  - i_Shuffle during SEARCH → no o_Valid, o_Card unchanged, o_Remaining=52.
  - i_Shuffle and i_Req together in IDLE → no deal, o_Busy stays 0.
- Mid-operation reset: i_Reset=0 during SEARCH → next cycle state IDLE, o_Remaining=52, o_Card=0, o_Valid=0, o_Busy=0.
